tile_spawner: RTL and testbench

- Downstream counterpart of the summation stage in the 2048 game logic.
- Accepts the post-move 4x4 tile matrix when `enable` is raised. Searches for an empty cell starting at a pseudo-random index, writes a new tile there, and returns the result with a `ready` level handshake.
- Flags a full board for the game-over logic.

---
 rtl/game_2048_pkg.sv | 19 +
 rtl/lfsr16.sv | 23 ++
 rtl/tile_spawner.sv | 105 ++++++++++
 tb/tb_tile_spawner.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/game_2048_pkg.sv
// Shared types and constants for the 2048 game datapath blocks.
package game_2048_pkg;

  localparam int GRID_N = 4;
  localparam int TILE_W = 12;

  typedef logic [TILE_W-1:0] tile_t;
  typedef tile_t [GRID_N-1:0][GRID_N-1:0] matrix_t;

  typedef enum logic [1:0] {
    SP_IDLE = 2'd0,
    SP_SCAN = 2'd1,
    SP_DONE = 2'd2
  } spawn_state_e;

  localparam tile_t TILE_TWO  = tile_t'(2);
  localparam tile_t TILE_FOUR = tile_t'(4);

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11.
// Shifts left; the feedback bit enters at q[0].
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic fb;
  assign fb = q[15] ^ q[13] ^ q[12] ^ q[10];

  // advance every cycle; reload seed on reset
  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= {q[14:0], fb};
  end

  // an all-zero seed would lock the register at zero forever
  seed_nonzero_a : assert property (@(posedge clk) SEED != 16'h0000);

endmodule

// File: rtl/tile_spawner.sv
// 2048 tile spawner: latches the post-move board, scans for an empty cell
// from a pseudo-random start index and inserts a new tile there.
// Optional macro TILE_SPAWNER_FOUR_EN: spawn a 4 instead of a 2 when
// lfsr[7:4] is zero at the write edge.
module tile_spawner
  import game_2048_pkg::*;
#(
  parameter int          TILE_W = 12,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [3:0][3:0][TILE_W-1:0]  matrix,
  output logic [3:0][3:0][TILE_W-1:0]  spawned_matrix,
  output logic                         ready,
  output logic                         full
);

  localparam logic [1:0] ST_IDLE = SP_IDLE;
  localparam logic [1:0] ST_SCAN = SP_SCAN;
  localparam logic [1:0] ST_DONE = SP_DONE;

  logic [1:0]                        state;
  logic [3:0]                        idx;
  logic [3:0]                        cnt;
  logic [3:0][3:0][TILE_W-1:0]       copy;
  logic [3:0][3:0][TILE_W-1:0]       spawn_mat;
  logic [TILE_W-1:0]                 new_tile;
  logic [15:0]                       lfsr_q;
  logic                              cell_empty;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

`ifdef TILE_SPAWNER_FOUR_EN
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr_q[15:8];
  assign new_tile = (lfsr_q[7:4] == 4'b0000) ? TILE_W'(TILE_FOUR) : TILE_W'(TILE_TWO);
`else
  logic unused_lfsr_bits;
  assign unused_lfsr_bits = ^lfsr_q[15:4];
  assign new_tile = TILE_W'(TILE_TWO);
`endif

  assign cell_empty = (copy[idx[3:2]][idx[1:0]] == '0);

  // latched board with the new tile dropped at the current scan index
  always_comb begin
    spawn_mat = copy;
    spawn_mat[idx[3:2]][idx[1:0]] = new_tile;
  end

  // request/scan/hold controller; one cell examined per cycle in SCAN
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      ready          <= 1'b0;
      full           <= 1'b0;
      spawned_matrix <= '0;
      copy           <= '0;
      idx            <= '0;
      cnt            <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            copy  <= matrix;
            idx   <= lfsr_q[3:0];
            cnt   <= '0;
            state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cell_empty) begin
            spawned_matrix <= spawn_mat;
            full           <= 1'b0;
            ready          <= 1'b1;
            state          <= ST_DONE;
          end else if (cnt == 4'd15) begin
            spawned_matrix <= copy;
            full           <= 1'b1;
            ready          <= 1'b1;
            state          <= ST_DONE;
          end else begin
            idx <= idx + 4'd1;
            cnt <= cnt + 4'd1;
          end
        end
        ST_DONE: begin
          // hold the result until the requester drops enable
          if (!enable) begin
            ready <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_spawner.sv
// Directed bench for tile_spawner with hand-derived expectations.
module tb_tile_spawner;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam int MW = 16 * 12;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    enable;
  logic [3:0][3:0][11:0]   matrix;
  logic [3:0][3:0][11:0]   spawned_matrix;
  logic                    ready;
  logic                    full;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] m_lfsr;

  tile_spawner #(.TILE_W(12), .SEED(SEED)) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .matrix         (matrix),
    .spawned_matrix (spawned_matrix),
    .ready          (ready),
    .full           (full)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // reference LFSR straight from the polynomial
  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= lstep(m_lfsr);
  end

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MW-1:0] fill(input logic [11:0] v);
    logic [3:0][3:0][11:0] r;
    for (int i = 0; i < 16; i++) r[i/4][i%4] = v;
    return r;
  endfunction

  // clock edges until ready, enable sampled on the first one
  task automatic wait_ready(output int edges);
    edges = 0;
    while (!ready && edges < 24) begin
      tick();
      edges++;
    end
  endtask

  initial begin
    int e;
    int exp_edges;
    int rises;
    int changes;
    int nz;
    logic prev;
    logic [3:0] i0;
    logic [15:0] wl;
    logic [11:0] newv;
    logic [3:0][3:0][11:0] hole;
    logic [3:0][3:0][11:0] expm;

    rst = 1'b1; enable = 1'b1; matrix = fill(12'd8);
    #2;
    tick(); tick();
    chk("rst_ready", MW'(ready), MW'(0));
    chk("rst_full", MW'(full), MW'(0));
    chk("rst_spawn", spawned_matrix, '0);
    chk("rst_lfsr", MW'(dut.u_lfsr.q), MW'(SEED));

    rst = 1'b0; enable = 1'b0;
    tick(); tick(); tick();
    chk("idle_ready", MW'(ready), MW'(0));
    chk("idle_spawn", spawned_matrix, '0);
    chk("lfsr_seq", MW'(dut.u_lfsr.q), MW'(m_lfsr));

    // single hole at [2][1] = index 9
    hole = fill(12'd2); hole[2][1] = 12'd0;
    matrix = hole; i0 = m_lfsr[3:0];
    exp_edges = int'(4'(4'd9 - i0)) + 2;
    enable = 1'b1;
    wait_ready(e);
    chk("hole_lat", MW'(e), MW'(exp_edges));
    chk("hole_full", MW'(full), MW'(0));
    chk("hole_spawn", spawned_matrix, fill(12'd2));
    enable = 1'b0;
    tick();
    chk("hole_drop", MW'(ready), MW'(0));
    chk("hole_keep", spawned_matrix, fill(12'd2));

    // full board
    matrix = fill(12'd8); enable = 1'b1;
    wait_ready(e);
    chk("full_lat", MW'(e), MW'(17));
    chk("full_flag", MW'(full), MW'(1));
    chk("full_spawn", spawned_matrix, fill(12'd8));
    enable = 1'b0;
    tick();
    chk("full_drop", MW'(ready), MW'(0));
    chk("full_keep", MW'(full), MW'(1));

    // empty board: first examined cell wins
    matrix = '0; i0 = m_lfsr[3:0]; wl = lstep(m_lfsr);
`ifdef TILE_SPAWNER_FOUR_EN
    newv = (wl[7:4] == 4'd0) ? 12'd4 : 12'd2;
`else
    newv = 12'd2;
`endif
    expm = '0; expm[i0[3:2]][i0[1:0]] = newv;
    enable = 1'b1;
    wait_ready(e);
    chk("empty_lat", MW'(e), MW'(2));
    chk("empty_full", MW'(full), MW'(0));
    chk("empty_spawn", spawned_matrix, expm);
    nz = 0;
    for (int k = 0; k < 16; k++) if (spawned_matrix[k/4][k%4] != 0) nz++;
    chk("empty_one", MW'(nz), MW'(1));
    enable = 1'b0;
    tick();

    // reset in the middle of a full-board scan (rst on edge 5)
    matrix = fill(12'd8); enable = 1'b1;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("mrst_ready", MW'(ready), MW'(0));
    chk("mrst_full", MW'(full), MW'(0));
    chk("mrst_state", MW'(dut.state), MW'(0));
    chk("mrst_lfsr", MW'(dut.u_lfsr.q), MW'(SEED));
    rst = 1'b0;
    matrix = hole; i0 = m_lfsr[3:0];
    exp_edges = int'(4'(4'd9 - i0)) + 2;
    wait_ready(e);
    chk("mrst_again", MW'(e), MW'(exp_edges));
    chk("mrst_spawn", spawned_matrix, fill(12'd2));

    // hold enable; input overwritten during the scan must be ignored
    enable = 1'b0;
    tick();
    matrix = hole; enable = 1'b1;
    rises = 0; changes = 0; prev = ready;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (k == 1) matrix = fill(12'd8);
      if (ready && !prev) rises++;
      if (ready && spawned_matrix !== fill(12'd2)) changes++;
      prev = ready;
    end
    chk("hold_rises", MW'(rises), MW'(1));
    chk("hold_changes", MW'(changes), MW'(0));
    chk("hold_ready", MW'(ready), MW'(1));
    enable = 1'b0;
    tick();
    chk("hold_drop", MW'(ready), MW'(0));
    chk("hold_keep", spawned_matrix, fill(12'd2));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
